// File: rtl/xbar_pkg.sv
// Shared helpers for the round-robin crossbar: index-width and flattened-bus slicing.
package xbar_pkg;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int slice_lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: fixed-priority search starting at the pointer, wrapping at N.
// The pointer only moves when a grant is actually issued.
module rr_arbiter
   import xbar_pkg::*;
#(
   parameter  int N  = 2,
   localparam int SW = clog2_min1(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] gnt_idx
);

   logic [SW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] cand;
   logic          found;
   int            idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         cand = SW'(idx);
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      ptr_d = ptr_q;
      if (found && en) begin
         gnt[gnt_idx] = 1'b1;
         // wrap explicitly at N, which need not be a power of two
         ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/xbar_rr.sv
// Registered N_IN x N_OUT crossbar with per-output round-robin arbitration and a
// single backpressured output register per port.
module xbar_rr
   import xbar_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N_IN  = 2,
   parameter  int N_OUT = 2,
   localparam int DW    = clog2_min1(N_OUT),
   localparam int SW    = clog2_min1(N_IN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_IN-1:0]        in_valid,
   input  logic [N_IN*WIDTH-1:0]  in_data,
   input  logic [N_IN*DW-1:0]     in_dest,
   output logic [N_IN-1:0]        in_ready,
   output logic [N_OUT-1:0]       out_valid,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic [N_OUT*SW-1:0]    out_src,
   input  logic [N_OUT-1:0]       out_ready,
   output logic                   drop
);

   logic [WIDTH-1:0] in_word [N_IN];
   logic [DW-1:0]    in_idx  [N_IN];
   logic [N_IN-1:0]  oor;
   logic [N_IN-1:0]  req     [N_OUT];
   logic [N_IN-1:0]  gnt     [N_OUT];
   logic [SW-1:0]    gnt_idx [N_OUT];
   logic [N_OUT-1:0] can_load;
   logic             vld_q   [N_OUT];
   logic [WIDTH-1:0] data_q  [N_OUT];
   logic [SW-1:0]    src_q   [N_OUT];
   logic [N_IN-1:0]  ready_c;
   logic             drop_q, drop_d;

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      assign in_word[i] = in_data[slice_lsb(i, WIDTH) +: WIDTH];
      assign in_idx[i]  = in_dest[slice_lsb(i, DW) +: DW];
      assign oor[i]     = int'(in_idx[i]) >= N_OUT;
   end

   for (genvar o = 0; o < N_OUT; o++) begin : g_out
      for (genvar i = 0; i < N_IN; i++) begin : g_req
         assign req[o][i] = in_valid[i] && (in_idx[i] == DW'(o));
      end

      assign can_load[o] = !vld_q[o] || out_ready[o];

      rr_arbiter #(.N(N_IN)) u_arb (
         .clk     (clk),
         .rst_n   (rst_n),
         .req     (req[o]),
         .en      (can_load[o]),
         .gnt     (gnt[o]),
         .gnt_idx (gnt_idx[o])
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q[o]  <= 1'b0;
            data_q[o] <= '0;
            src_q[o]  <= '0;
         end else if (|gnt[o]) begin
            vld_q[o]  <= 1'b1;
            data_q[o] <= in_word[gnt_idx[o]];
            src_q[o]  <= gnt_idx[o];
         end else if (out_ready[o]) begin
            vld_q[o]  <= 1'b0;
         end
      end

      assign out_valid[o]                          = vld_q[o];
      assign out_data[slice_lsb(o, WIDTH) +: WIDTH] = data_q[o];
      assign out_src[slice_lsb(o, SW) +: SW]        = src_q[o];
   end

   // Out-of-range requests are always consumed so they can never wedge an input.
   always_comb begin
      ready_c = oor;
      for (int o = 0; o < N_OUT; o++) ready_c = ready_c | gnt[o];
      in_ready = rst_n ? ready_c : '0;
      drop_d   = |(in_valid & oor);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_q <= 1'b0;
      else        drop_q <= drop_d;
   end

   assign drop = drop_q;

endmodule

// File: tb/tb_xbar_rr.sv
// Directed scoreboard bench for a 4x3, 8-bit crossbar instance.
module tb_xbar_rr;

   typedef logic [9:0] ent_t;  // {src[1:0], data[7:0]}

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [7:0]  in_dest;
   logic [3:0]  in_ready;
   logic [2:0]  out_valid;
   logic [23:0] out_data;
   logic [5:0]  out_src;
   logic [2:0]  out_ready;
   logic        drop;

   int   total  = 0;
   int   passed = 0;
   logic exp_drop = 1'b0;
   ent_t q0 [$];
   ent_t q1 [$];
   ent_t q2 [$];

   xbar_rr #(.WIDTH(8), .N_IN(4), .N_OUT(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int qsz(input int o);
      case (o)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic ent_t qfront(input int o);
      case (o)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpop(input int o);
      case (o)
         0:       void'(q0.pop_front());
         1:       void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endtask

   task automatic qpush(input int o, input ent_t e);
      case (o)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: every held word must match the head of its output's queue.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int o = 0; o < 3; o++) begin
            if (out_valid[o]) begin
               if (qsz(o) == 0) begin
                  check($sformatf("out%0d_spurious", o), {31'b0, out_valid[o]}, 32'd0);
               end else begin
                  check($sformatf("out%0d_word", o),
                        {22'b0, out_src[o*2 +: 2], out_data[o*8 +: 8]}, {22'b0, qfront(o)});
                  if (out_ready[o]) qpop(o);
               end
            end
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the next one.
   task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [7:0] dst,
                       input logic [2:0] ordy, input logic [3:0] exp_rdy);
      logic       drop_n;
      logic [1:0] dd;
      in_valid  = v;
      in_data   = d;
      in_dest   = dst;
      out_ready = ordy;
      @(negedge clk);
      check("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
      check("drop", {31'b0, drop}, {31'b0, exp_drop});
      drop_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (exp_rdy[i] && v[i]) begin
            dd = dst[i*2 +: 2];
            if (dd == 2'd3) drop_n = 1'b1;
            else qpush(int'(dd), {2'(i), d[i*8 +: 8]});
         end
      end
      @(posedge clk);
      #1;
      exp_drop = drop_n;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b0011;
      in_data   = '0;
      in_dest   = '0;
      out_ready = 3'b111;
      #3;
      check("rst_in_ready", {28'b0, in_ready}, 32'd0);
      check("rst_out_valid", {29'b0, out_valid}, 32'd0);
      check("rst_out_data", {8'b0, out_data}, 32'd0);
      check("rst_out_src", {26'b0, out_src}, 32'd0);
      check("rst_drop", {31'b0, drop}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // distinct destinations, then two-way contention on output 0
      step(4'b0011, {8'h00, 8'h00, 8'h0B, 8'h0A}, {2'd0, 2'd0, 2'd1, 2'd0}, 3'b111, 4'b0011);
      step(4'b0011, {8'h00, 8'h00, 8'h11, 8'h10}, 8'h00, 3'b111, 4'b0010);
      step(4'b0011, {8'h00, 8'h00, 8'h12, 8'h10}, 8'h00, 3'b111, 4'b0001);
      step(4'b0011, {8'h00, 8'h00, 8'h12, 8'h13}, 8'h00, 3'b111, 4'b0010);
      step(4'b0011, {8'h00, 8'h00, 8'h14, 8'h13}, 8'h00, 3'b111, 4'b0001);
      step(4'b0010, {8'h00, 8'h00, 8'h14, 8'h13}, 8'h00, 3'b111, 4'b0010);
      step(4'b0000, 32'h0, 8'h00, 3'b111, 4'b0000);

      // backpressure on output 0 for three cycles, pointer must hold at 3
      step(4'b0100, {8'h00, 8'h20, 8'h00, 8'h00}, 8'h00, 3'b111, 4'b0100);
      step(4'b1100, {8'h30, 8'h21, 8'h00, 8'h00}, 8'h00, 3'b110, 4'b0000);
      step(4'b1100, {8'h30, 8'h21, 8'h00, 8'h00}, 8'h00, 3'b110, 4'b0000);
      step(4'b1100, {8'h30, 8'h21, 8'h00, 8'h00}, 8'h00, 3'b110, 4'b0000);
      step(4'b1100, {8'h30, 8'h21, 8'h00, 8'h00}, 8'h00, 3'b111, 4'b1000);
      step(4'b0100, {8'h30, 8'h21, 8'h00, 8'h00}, 8'h00, 3'b111, 4'b0100);
      step(4'b0000, 32'h0, 8'h00, 3'b111, 4'b0000);

      // out-of-range destination alongside legal traffic on outputs 1 and 2
      step(4'b1011, {8'hC2, 8'h00, 8'hB1, 8'hFF}, {2'd2, 2'd0, 2'd1, 2'd3}, 3'b111, 4'b1011);
      step(4'b0000, 32'h0, 8'h00, 3'b111, 4'b0000);
      step(4'b0000, 32'h0, 8'h00, 3'b111, 4'b0000);

      // fill all outputs, then reset between edges
      step(4'b0111, {8'h00, 8'hE2, 8'hE1, 8'hE0}, {2'd0, 2'd2, 2'd1, 2'd0}, 3'b111, 4'b0111);
      check("pre_rst_out_valid", {29'b0, out_valid}, 32'h7);
      in_valid  = 4'b0011;
      in_dest   = 8'h00;
      out_ready = 3'b000;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", {29'b0, out_valid}, 32'd0);
      check("async_rst_in_ready", {28'b0, in_ready}, 32'd0);
      q0.delete();
      q1.delete();
      q2.delete();
      exp_drop = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // pointer back at 0: input 0 wins first
      step(4'b0011, {8'h00, 8'h00, 8'hF1, 8'hF0}, 8'h00, 3'b111, 4'b0001);
      step(4'b0010, {8'h00, 8'h00, 8'hF1, 8'hF0}, 8'h00, 3'b111, 4'b0010);
      step(4'b0000, 32'h0, 8'h00, 3'b111, 4'b0000);

      for (int n = 0; n < 20 && (qsz(0) + qsz(1) + qsz(2)) != 0; n++) begin
         @(posedge clk);
         #1;
      end
      check("q0_drained", qsz(0), 32'd0);
      check("q1_drained", qsz(1), 32'd0);
      check("q2_drained", qsz(2), 32'd0);
      check("final_out_valid", {29'b0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
